// File: rtl/lcd_pkg.sv
// Shared types, ROMs and helpers for the Spartan-3E character LCD
// write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT_NIB,
    S_INIT_WAIT,
    S_HI,
    S_GAP,
    S_LO,
    S_WAIT,
    S_IDLE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ENABLE,
    PH_HOLD
  } phase_e;

  typedef enum logic [1:0] {
    W_INIT1,
    W_INIT2,
    W_INIT3
  } init_wait_e;

  localparam logic [1:0] LAST_IDX = 2'd3;

  function automatic logic [3:0] init_nibble(
    input logic [1:0] idx
  );
    logic [3:0] n;
    unique case (idx)
      2'd3:    n = 4'h2;
      default: n = 4'h3;
    endcase
    return n;
  endfunction

  function automatic init_wait_e init_wait_sel(
    input logic [1:0] idx
  );
    init_wait_e w;
    unique case (idx)
      2'd0:    w = W_INIT1;
      2'd1:    w = W_INIT2;
      default: w = W_INIT3;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] cfg_byte(
    input logic [1:0] idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = 8'h28;
      2'd1:    b = 8'h06;
      2'd2:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // Clear and Home need the long execution wait
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] b
  );
    return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_sequencer_strobe.sv
// One LCD nibble transfer: setup, enable pulse, hold; pulses done
// in the last hold cycle.
module lcd_nibble_strobe
  import lcd_pkg::*;
#(
  parameter int P_SETUP  = 2,
  parameter int P_ENABLE = 12,
  parameter int P_HOLD   = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [3:0] iNibble,
  input  logic       iRS,
  output logic       oDone,
  output logic       oE,
  output logic       oRS,
  output logic [3:0] oData
);

  localparam int SMAX =
    max2(P_SETUP, max2(P_ENABLE, P_HOLD));
  localparam int SW = $clog2(SMAX) + 1;

  localparam logic [SW-1:0] L_SETUP  = SW'(P_SETUP - 1);
  localparam logic [SW-1:0] L_ENABLE = SW'(P_ENABLE - 1);
  localparam logic [SW-1:0] L_HOLD   = SW'(P_HOLD - 1);

  phase_e        phase_q, phase_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    data_q, data_d;
  logic          rs_q, rs_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - SW'(1) : cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    oDone   = 1'b0;
    unique case (phase_q)
      PH_IDLE: begin
        if (iStart) begin
          phase_d = PH_SETUP;
          cnt_d   = L_SETUP;
          data_d  = iNibble;
          rs_d    = iRS;
        end
      end
      PH_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = PH_ENABLE;
          cnt_d   = L_ENABLE;
        end
      end
      PH_ENABLE: begin
        if (cnt_q == '0) begin
          phase_d = PH_HOLD;
          cnt_d   = L_HOLD;
        end
      end
      PH_HOLD: begin
        if (cnt_q == '0) begin
          phase_d = PH_IDLE;
          oDone   = 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      data_q  <= 4'h0;
      rs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
    end
  end

  assign oE    = (phase_q == PH_ENABLE);
  assign oRS   = rs_q;
  assign oData = data_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Owns the LCD 4-bit bus: power-on init, configuration, then
// handshaked command/data byte writes with all LCD waits enforced.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int P_POWERUP  = 750000,
  parameter int P_INIT_W1  = 205000,
  parameter int P_INIT_W2  = 5000,
  parameter int P_INIT_W3  = 2000,
  parameter int P_SETUP    = 2,
  parameter int P_ENABLE   = 12,
  parameter int P_HOLD     = 1,
  parameter int P_GAP      = 50,
  parameter int P_CMD_WAIT = 2000,
  parameter int P_CLR_WAIT = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam int PMAX =
    max2(P_POWERUP,
    max2(P_INIT_W1,
    max2(P_INIT_W2,
    max2(P_INIT_W3,
    max2(P_SETUP,
    max2(P_ENABLE,
    max2(P_HOLD,
    max2(P_GAP,
    max2(P_CMD_WAIT, P_CLR_WAIT)))))))));
  localparam int CW = $clog2(PMAX) + 1;

  localparam logic [CW-1:0] L_PWR = CW'(P_POWERUP - 1);
  localparam logic [CW-1:0] L_W1  = CW'(P_INIT_W1 - 1);
  localparam logic [CW-1:0] L_W2  = CW'(P_INIT_W2 - 1);
  localparam logic [CW-1:0] L_W3  = CW'(P_INIT_W3 - 1);
  localparam logic [CW-1:0] L_GAP = CW'(P_GAP - 1);
  localparam logic [CW-1:0] L_CMD = CW'(P_CMD_WAIT - 1);
  localparam logic [CW-1:0] L_CLR = CW'(P_CLR_WAIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d;
  logic          cfg_q, cfg_d;
  logic          done_q, done_d;

  logic       s_start;
  logic [3:0] s_nib;
  logic       s_rs;
  logic       s_done;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    cfg_d   = cfg_q;
    s_start = 1'b0;
    s_nib   = 4'h0;
    s_rs    = 1'b0;
    unique case (state_q)
      S_POWERUP: begin
        if (cnt_q == '0) begin
          idx_d   = 2'd0;
          s_start = 1'b1;
          s_nib   = init_nibble(2'd0);
          state_d = S_INIT_NIB;
        end
      end
      S_INIT_NIB: begin
        if (s_done) begin
          state_d = S_INIT_WAIT;
          unique case (init_wait_sel(idx_q))
            W_INIT1: cnt_d = L_W1;
            W_INIT2: cnt_d = L_W2;
            default: cnt_d = L_W3;
          endcase
        end
      end
      S_INIT_WAIT: begin
        if (cnt_q == '0) begin
          s_start = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = 2'd0;
            byte_d  = cfg_byte(2'd0);
            rs_d    = 1'b0;
            cfg_d   = 1'b1;
            s_nib   = byte_d[7:4];
            state_d = S_HI;
          end else begin
            idx_d   = idx_q + 2'd1;
            s_nib   = init_nibble(idx_d);
            state_d = S_INIT_NIB;
          end
        end
      end
      S_HI: begin
        if (s_done) begin
          state_d = S_GAP;
          cnt_d   = L_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          s_start = 1'b1;
          s_nib   = byte_q[3:0];
          s_rs    = rs_q;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (s_done) begin
          state_d = S_WAIT;
          cnt_d   = is_long_cmd(rs_q, byte_q) ? L_CLR : L_CMD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (cfg_q && idx_q != LAST_IDX) begin
            idx_d   = idx_q + 2'd1;
            byte_d  = cfg_byte(idx_d);
            s_start = 1'b1;
            s_nib   = byte_d[7:4];
            state_d = S_HI;
          end else begin
            cfg_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (iValid) begin
          byte_d  = iData;
          rs_d    = iRS;
          s_start = 1'b1;
          s_nib   = iData[7:4];
          s_rs    = iRS;
          state_d = S_HI;
        end
      end
      default: begin
        state_d = S_POWERUP;
        cnt_d   = L_PWR;
      end
    endcase
    done_d = done_q | (state_d == S_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_POWERUP;
      cnt_q   <= L_PWR;
      idx_q   <= 2'd0;
      byte_q  <= 8'h00;
      rs_q    <= 1'b0;
      cfg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

  lcd_nibble_strobe #(
    .P_SETUP  (P_SETUP),
    .P_ENABLE (P_ENABLE),
    .P_HOLD   (P_HOLD)
  ) u_strobe (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (s_start),
    .iNibble (s_nib),
    .iRS     (s_rs),
    .oDone   (s_done),
    .oE      (oLCD_Enabled),
    .oRS     (oLCD_RegisterSelect),
    .oData   (oLCD_Data)
  );

  assign oReady                  = (state_q == S_IDLE);
  assign oInitDone               = done_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened LCD timings.
module tb_lcd_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       iValid;
  logic       iRS;
  logic [7:0] iData;
  logic       oReady;
  logic       oInitDone;
  logic       oE;
  logic       oRSel;
  logic       oRW;
  logic       oSF;
  logic [3:0] oData;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         p_start[$];
  logic [3:0] p_nib[$];
  logic       p_rs[$];
  int         p_w[$];
  logic       e_prev    = 1'b0;
  int         glitch    = 0;
  int         bad_const = 0;

  lcd_write_sequencer #(
    .P_POWERUP  (20),
    .P_INIT_W1  (10),
    .P_INIT_W2  (5),
    .P_INIT_W3  (3),
    .P_SETUP    (2),
    .P_ENABLE   (3),
    .P_HOLD     (1),
    .P_GAP      (4),
    .P_CMD_WAIT (6),
    .P_CLR_WAIT (15)
  ) dut (
    .Clock                   (clk),
    .Reset                   (rst),
    .iValid                  (iValid),
    .iRS                     (iRS),
    .iData                   (iData),
    .oReady                  (oReady),
    .oInitDone               (oInitDone),
    .oLCD_Enabled            (oE),
    .oLCD_RegisterSelect     (oRSel),
    .oLCD_ReadWrite          (oRW),
    .oLCD_StrataFlashControl (oSF),
    .oLCD_Data               (oData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each E pulse: start cycle, nibble, RS and width
  always @(negedge clk) begin
    if (oRW !== 1'b0 || oSF !== 1'b1) bad_const++;
    if (oE === 1'b1) begin
      if (!e_prev) begin
        p_start.push_back(cyc);
        p_nib.push_back(oData);
        p_rs.push_back(oRSel);
        p_w.push_back(1);
      end else begin
        p_w[p_w.size()-1] = p_w[p_w.size()-1] + 1;
        if (oData !== p_nib[p_nib.size()-1]) glitch++;
      end
    end
    e_prev = (oE === 1'b1);
  end

  task automatic clear_log();
    p_start.delete();
    p_nib.delete();
    p_rs.delete();
    p_w.delete();
  endtask

  task automatic wait_ready(input int lim, output bit ok);
    int n = 0;
    while (oReady !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    ok = (oReady === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; iValid = 1'b0; iRS = 1'b0; iData = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (oReady !== 1'b0) begin
      failures++; $display("FAIL rst_ready got=%b exp=0", oReady);
    end
    checks++;
    if (oInitDone !== 1'b0) begin
      failures++; $display("FAIL rst_initdone got=%b exp=0", oInitDone);
    end
    checks++;
    if (oE !== 1'b0 || oRSel !== 1'b0 || oData !== 4'h0) begin
      failures++;
      $display("FAIL rst_bus got E=%b RS=%b D=%h exp 0/0/0", oE, oRSel, oData);
    end
    checks++;
    if (oRW !== 1'b0 || oSF !== 1'b1) begin
      failures++; $display("FAIL rst_const got RW=%b SF=%b exp 0/1", oRW, oSF);
    end
  endtask

  // Releases reset and checks the complete init + config sequence
  task automatic test_init();
    logic [3:0] exp_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    int exp_gap [12] = '{0, 16, 11, 9, 9, 10, 12, 10, 12, 10, 12, 10};
    int n = 0;
    int early = 0;
    int bad = 0;
    rst = 1'b0;
    clear_log();
    while (oReady !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (oInitDone === 1'b1 && oReady !== 1'b1) early++;
    end
    checks++;
    if (oReady !== 1'b1) begin
      failures++; $display("FAIL init_timeout ready=%b exp=1", oReady);
    end
    checks++;
    if (oInitDone !== 1'b1 || early != 0) begin
      failures++;
      $display("FAIL init_done got=%b early=%0d exp 1/0", oInitDone, early);
    end
    checks++;
    if (p_start.size() != 12) begin
      failures++; $display("FAIL init_pulses got=%0d exp=12", p_start.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (p_nib[i] !== exp_nib[i] || p_rs[i] !== 1'b0 || p_w[i] != 3) bad++;
        if (i > 0 && p_start[i] - p_start[i-1] != exp_gap[i]) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL init_nibbles bad=%0d exp=0", bad);
      end
      checks++;
      if (cyc - (p_start[11] + 2) != 17) begin
        failures++;
        $display("FAIL init_clr_wait got=%0d exp=17", cyc - (p_start[11] + 2));
      end
    end
  endtask

  task automatic test_write_data();
    int t0;
    bit ok;
    clear_log();
    checks++;
    if (oReady !== 1'b1) begin
      failures++; $display("FAIL wr_pre_ready got=%b exp=1", oReady);
    end
    iValid = 1'b1; iRS = 1'b1; iData = 8'h41; t0 = cyc;
    @(negedge clk);
    iValid = 1'b0; iData = 8'h00; iRS = 1'b0;
    checks++;
    if (oReady !== 1'b0) begin
      failures++; $display("FAIL wr_ready_drop got=%b exp=0", oReady);
    end
    wait_ready(200, ok);
    checks++;
    if (!ok || cyc - t0 != 23) begin
      failures++; $display("FAIL wr_ready_ret got=%0d exp=23", cyc - t0);
    end
    checks++;
    if (p_start.size() != 2) begin
      failures++; $display("FAIL wr_pulses got=%0d exp=2", p_start.size());
    end else begin
      checks++;
      if (p_start[0] != t0 + 3 || p_nib[0] !== 4'h4 || p_rs[0] !== 1'b1
          || p_w[0] != 3) begin
        failures++;
        $display("FAIL wr_hi got t=%0d n=%h rs=%b w=%0d exp t=3 n=4 rs=1 w=3",
                 p_start[0] - t0, p_nib[0], p_rs[0], p_w[0]);
      end
      checks++;
      if (p_start[1] != t0 + 13 || p_nib[1] !== 4'h1 || p_rs[1] !== 1'b1
          || p_w[1] != 3) begin
        failures++;
        $display("FAIL wr_lo got t=%0d n=%h rs=%b w=%0d exp t=13 n=1 rs=1 w=3",
                 p_start[1] - t0, p_nib[1], p_rs[1], p_w[1]);
      end
    end
  endtask

  task automatic test_long_cmd();
    logic       rs_v [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] d_v  [4] = '{8'h01, 8'h01, 8'h03, 8'h04};
    int         exp  [4] = '{32, 23, 32, 23};
    int t0;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      iValid = 1'b1; iRS = rs_v[k]; iData = d_v[k]; t0 = cyc;
      @(negedge clk);
      iValid = 1'b0;
      wait_ready(200, ok);
      checks++;
      if (!ok || cyc - t0 != exp[k]) begin
        failures++;
        $display("FAIL long_cmd rs=%b d=%h got=%0d exp=%0d",
                 rs_v[k], d_v[k], cyc - t0, exp[k]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int t0;
    bit ok;
    clear_log();
    iValid = 1'b1; iRS = 1'b1; iData = 8'hA7; t0 = cyc;
    @(negedge clk);
    iValid = 1'b0;
    repeat (4) @(negedge clk);
    iValid = 1'b1; iRS = 1'b0; iData = 8'h55;
    @(negedge clk);
    iValid = 1'b0;
    wait_ready(200, ok);
    checks++;
    if (!ok || cyc - t0 != 23) begin
      failures++; $display("FAIL busy_ready got=%0d exp=23", cyc - t0);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (p_start.size() != 2 || oReady !== 1'b1) begin
      failures++;
      $display("FAIL busy_extra pulses=%0d ready=%b exp 2/1",
               p_start.size(), oReady);
    end else begin
      checks++;
      if (p_nib[0] !== 4'hA || p_nib[1] !== 4'h7 || p_rs[0] !== 1'b1
          || p_rs[1] !== 1'b1) begin
        failures++;
        $display("FAIL busy_latch got %h%h rs=%b%b exp A7 rs=11",
                 p_nib[0], p_nib[1], p_rs[0], p_rs[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    iValid = 1'b1; iRS = 1'b1; iData = 8'h41;
    @(negedge clk);
    iValid = 1'b0;
    while (oE !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (oE !== 1'b1) begin
      failures++; $display("FAIL mid_e_seen got=%b exp=1", oE);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (oE !== 1'b0 || oReady !== 1'b0 || oInitDone !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got E=%b R=%b D=%b exp 0/0/0",
               oE, oReady, oInitDone);
    end
    test_init();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3] = '{8'h48, 8'h69, 8'h21};
    int t [3];
    int n;
    int bad = 0;
    bit ok;
    clear_log();
    iValid = 1'b1; iRS = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iData = b[k];
      n = 0;
      while (oReady !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      t[k] = cyc;
      @(negedge clk);
    end
    iValid = 1'b0;
    wait_ready(200, ok);
    checks++;
    if (!ok || t[1] - t[0] != 23 || t[2] - t[1] != 23) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d,%0d exp=23,23",
               t[1] - t[0], t[2] - t[1]);
    end
    checks++;
    if (p_start.size() != 6) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=6", p_start.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (p_nib[2*k] !== b[k][7:4] || p_nib[2*k+1] !== b[k][3:0]) bad++;
        if (p_start[2*k] != t[k] + 3) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL b2b_nibbles bad=%0d exp=0", bad);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_write_data();
    test_long_cmd();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (glitch != 0 || bad_const != 0) begin
      failures++;
      $display("FAIL bus_stable glitch=%0d const=%0d exp 0/0", glitch, bad_const);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
